// File: rtl/bht_predict_ctrl.sv
// Branch history table sequencer: predicts at fetch, tracks in-flight branches,
// updates 2-bit counters on resolution and drives mispredict flush/redirect.
module bht_predict_ctrl #(
  parameter int unsigned LOWER     = 5,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic [PC_W-1:0]  fetch_target,
  output logic             fetch_ready,
  output logic             pred_taken,
  output logic [LOWER-1:0] bht_rd_addr,
  input  logic [1:0]       bht_rd_data,
  output logic             bht_wr_en,
  output logic [LOWER-1:0] bht_wr_addr,
  output logic [1:0]       bht_wr_data,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_pc_next,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [15:0]      mispredict_cnt
);

  localparam int unsigned PW  = $clog2(QDEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  typedef struct packed {
    logic [LOWER-1:0] idx;
    logic [1:0]       ctr;
    logic             pred;
    logic [PC_W-1:0]  target;
  } entry_t;

  state_e          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  entry_t          fifo_q [QDEPTH];
  entry_t          fifo_d [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]     mcnt_q, mcnt_d;

  entry_t     head;
  logic       empty, full, pop, push, mispredict_now, fwd;
  logic [1:0] eff_ctr;
  logic       unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[PC_W-1:LOWER+2], fetch_pc[1:0]};

  assign head  = fifo_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(QDEPTH));

  // Resolution is only honoured in RUN with something in flight
  assign pop            = res_valid && !empty && (state_q == ST_RUN);
  assign mispredict_now = pop && (head.pred != res_taken);

  assign bht_wr_en   = pop;
  assign bht_wr_addr = head.idx;
  always_comb begin
    bht_wr_data = head.ctr;
    if (res_taken) begin
      if (head.ctr != 2'b11) bht_wr_data = head.ctr + 2'd1;
    end else begin
      if (head.ctr != 2'b00) bht_wr_data = head.ctr - 2'd1;
    end
  end

  assign bht_rd_addr = fetch_pc[LOWER+1:2];
  assign fwd         = bht_wr_en && (bht_wr_addr == bht_rd_addr);
  assign eff_ctr     = fwd ? bht_wr_data : bht_rd_data;
  assign pred_taken  = eff_ctr[1];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then
  assign fetch_ready = (state_q == ST_RUN) && (!full || pop) && !mispredict_now;
  assign push        = fetch_valid && fetch_ready;

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    fifo_d           = fifo_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mcnt_d           = mcnt_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{idx: bht_rd_addr, ctr: eff_ctr, pred: pred_taken, target: fetch_target};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_RUN: begin
        if (mispredict_now) begin
          state_d          = ST_FLUSH;
          fcnt_d           = FCW'(FLUSH_CYC - 1);
          wr_ptr_d         = '0;
          rd_ptr_d         = '0;
          cnt_d            = '0;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = res_taken ? head.target : res_pc_next;
          if (mcnt_q != '1) mcnt_d = mcnt_q + 16'd1;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_RUN;
        else              fcnt_d  = fcnt_q - FCW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q          <= ST_RUN;
      fcnt_q           <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mcnt_q           <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mcnt_q           <= mcnt_d;
      fifo_q           <= fifo_d;
    end
  end

  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_bht_predict_ctrl.sv
// Scoreboard bench for bht_predict_ctrl: stimulus queues expected table writes and
// redirects; a negedge monitor pops and compares whenever the DUT strobes them.
module tb_bht_predict_ctrl;
  localparam int unsigned LOWER = 5;
  localparam int unsigned PC_W  = 32;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             fetch_valid;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  fetch_target;
  logic             fetch_ready;
  logic             pred_taken;
  logic [LOWER-1:0] bht_rd_addr;
  logic [1:0]       bht_rd_data;
  logic             bht_wr_en;
  logic [LOWER-1:0] bht_wr_addr;
  logic [1:0]       bht_wr_data;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_pc_next;
  logic             flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [15:0]      mispredict_cnt;

  always #5 clk = ~clk;

  bht_predict_ctrl #(.LOWER(LOWER), .PC_W(PC_W), .QDEPTH(4), .FLUSH_CYC(2)) dut (
    .clk(clk), .arst_n(arst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_target(fetch_target),
    .fetch_ready(fetch_ready), .pred_taken(pred_taken),
    .bht_rd_addr(bht_rd_addr), .bht_rd_data(bht_rd_data),
    .bht_wr_en(bht_wr_en), .bht_wr_addr(bht_wr_addr), .bht_wr_data(bht_wr_data),
    .res_valid(res_valid), .res_taken(res_taken), .res_pc_next(res_pc_next),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    logic [LOWER-1:0] a;
    logic [1:0]       d;
  } wr_t;

  wr_t             wr_q [$];
  logic [PC_W-1:0] redir_q [$];
  int              n_chk  = 0;
  int              n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: every write strobe / redirect strobe must match the oldest expectation
  initial begin
    wr_t             e;
    logic [PC_W-1:0] p;
    forever begin
      @(negedge clk);
      if (bht_wr_en) begin
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_addr", 32'(bht_wr_addr), 32'(e.a));
          chk("wr_data", 32'(bht_wr_data), 32'(e.d));
        end else chk("unexpected_wr_en", 32'(bht_wr_en), 32'd0);
      end
      if (redirect_valid) begin
        if (redir_q.size() > 0) begin
          p = redir_q.pop_front();
          chk("redirect_pc", redirect_pc, p);
        end else chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic idle();
    fetch_valid = 1'b0;
    res_valid   = 1'b0;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_fetch(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input logic [1:0] rd);
    fetch_valid  = 1'b1;
    fetch_pc     = pc;
    fetch_target = tgt;
    bht_rd_data  = rd;
  endtask

  task automatic drive_res(input logic t, input logic [PC_W-1:0] pcn);
    res_valid   = 1'b1;
    res_taken   = t;
    res_pc_next = pcn;
  endtask

  task automatic expect_wr(input logic [LOWER-1:0] a, input logic [1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_flush"},          32'(flush),          32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_redirect_pc"},    redirect_pc,         32'd0);
    chk({tag, "_mcnt"},           32'(mispredict_cnt), 32'd0);
    chk({tag, "_wr_en"},          32'(bht_wr_en),      32'd0);
    chk({tag, "_fetch_ready"},    32'(fetch_ready),    32'd1);
  endtask

  initial begin
    arst_n = 1'b0;
    idle();
    fetch_pc = '0; fetch_target = '0; bht_rd_data = 2'b00;
    res_taken = 1'b0; res_pc_next = '0;

    // Reset, with a resolve attempt that must not write
    res_valid = 1'b1;
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    arst_n = 1'b1;
    idle();

    // 1: weakly-taken predicted and resolved taken
    drive_fetch(32'h40, 32'h80, 2'b10);
    @(negedge clk);
    chk("t1_rd_addr", 32'(bht_rd_addr), 32'h10);
    chk("t1_pred", 32'(pred_taken), 32'd1);
    chk("t1_ready", 32'(fetch_ready), 32'd1);
    cycle_end();
    drive_res(1'b1, 32'h44);
    expect_wr(5'h10, 2'b11);
    @(negedge clk);
    cycle_end();
    @(negedge clk);
    chk("t1_no_redirect", 32'(redirect_valid), 32'd0);
    cycle_end();

    // 2: saturation at both ends
    drive_fetch(32'h44, 32'h90, 2'b11);
    cycle_end();
    drive_fetch(32'h48, 32'hA0, 2'b00);
    @(negedge clk);
    chk("t2_pred_nt", 32'(pred_taken), 32'd0);
    cycle_end();
    drive_res(1'b1, 32'h48);
    expect_wr(5'h11, 2'b11);
    @(negedge clk);
    cycle_end();
    drive_res(1'b0, 32'h4C);
    expect_wr(5'h12, 2'b00);
    @(negedge clk);
    cycle_end();

    // 3: fill, full stall, push+pop while full, drain, empty resolve ignored
    for (int i = 0; i < 4; i++) begin
      drive_fetch(32'h200 + 32'(4 * i), 32'h1000, 2'b00);
      @(negedge clk);
      chk("t3_ready", 32'(fetch_ready), 32'd1);
      cycle_end();
    end
    drive_fetch(32'h210, 32'h1000, 2'b00);
    @(negedge clk);
    chk("t3_full_ready", 32'(fetch_ready), 32'd0);
    cycle_end();
    drive_fetch(32'h210, 32'h1000, 2'b00);
    drive_res(1'b0, 32'h204);
    expect_wr(5'd0, 2'b00);
    @(negedge clk);
    chk("t3_pushpop_ready", 32'(fetch_ready), 32'd1);
    cycle_end();
    drive_fetch(32'h214, 32'h1000, 2'b00);
    @(negedge clk);
    chk("t3_still_full", 32'(fetch_ready), 32'd0);
    cycle_end();
    for (int i = 1; i <= 4; i++) begin
      drive_res(1'b0, 32'h300);
      expect_wr(5'(i), 2'b00);
      @(negedge clk);
      cycle_end();
    end
    drive_res(1'b0, 32'h300);
    @(negedge clk);
    chk("t3_empty_ready", 32'(fetch_ready), 32'd1);
    cycle_end();

    // 4: not-taken prediction resolved taken -> redirect to target, 2-cycle flush
    drive_fetch(32'h300, 32'h100, 2'b01);
    @(negedge clk);
    chk("t4_pred", 32'(pred_taken), 32'd0);
    cycle_end();
    drive_res(1'b1, 32'h304);
    drive_fetch(32'h304, 32'h0, 2'b00);
    expect_wr(5'd0, 2'b10);
    redir_q.push_back(32'h100);
    @(negedge clk);
    chk("t4_mispredict_ready", 32'(fetch_ready), 32'd0);
    cycle_end();
    drive_res(1'b1, 32'h0);
    drive_fetch(32'h304, 32'h0, 2'b00);
    @(negedge clk);
    chk("t4_flush1", 32'(flush), 32'd1);
    chk("t4_ready1", 32'(fetch_ready), 32'd0);
    chk("t4_mcnt", 32'(mispredict_cnt), 32'd1);
    cycle_end();
    @(negedge clk);
    chk("t4_flush2", 32'(flush), 32'd1);
    chk("t4_ready2", 32'(fetch_ready), 32'd0);
    chk("t4_redirect_1cyc", 32'(redirect_valid), 32'd0);
    cycle_end();
    drive_res(1'b1, 32'h0);
    @(negedge clk);
    chk("t4_flush_done", 32'(flush), 32'd0);
    chk("t4_ready_after", 32'(fetch_ready), 32'd1);
    chk("t4_redirect_pc_hold", redirect_pc, 32'h100);
    cycle_end();

    // 5a: resolve index 3 (01, taken) while fetching index 3 -> forwarded 10
    drive_fetch(32'h0C, 32'h600, 2'b01);
    cycle_end();
    drive_res(1'b1, 32'h10);
    drive_fetch(32'h0C, 32'h600, 2'b01);
    expect_wr(5'd3, 2'b10);
    redir_q.push_back(32'h600);
    @(negedge clk);
    chk("t5_fwd_pred", 32'(pred_taken), 32'd1);
    chk("t5_fwd_ready", 32'(fetch_ready), 32'd0);
    cycle_end();
    repeat (2) cycle_end();
    @(negedge clk);
    chk("t5_mcnt", 32'(mispredict_cnt), 32'd2);
    cycle_end();

    // 5b: forwarded counter is what gets stored in the FIFO entry
    drive_fetch(32'h14, 32'h700, 2'b10);
    cycle_end();
    drive_res(1'b1, 32'h18);
    drive_fetch(32'h14, 32'h700, 2'b00);
    expect_wr(5'd5, 2'b11);
    @(negedge clk);
    chk("t5b_fwd_pred", 32'(pred_taken), 32'd1);
    chk("t5b_ready", 32'(fetch_ready), 32'd1);
    cycle_end();
    drive_res(1'b0, 32'h18);
    expect_wr(5'd5, 2'b10);
    redir_q.push_back(32'h18);
    @(negedge clk);
    cycle_end();
    repeat (2) cycle_end();
    @(negedge clk);
    chk("t5b_mcnt", 32'(mispredict_cnt), 32'd3);
    chk("t5b_redirect_pc", redirect_pc, 32'h18);
    cycle_end();

    // 6a: reset with 3 entries in flight
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h18 + 32'(4 * i), 32'h800, 2'b00);
      cycle_end();
    end
    arst_n = 1'b0;
    drive_res(1'b1, 32'h0);
    drive_fetch(32'h18, 32'h800, 2'b00);
    @(negedge clk);
    check_reset_values("t6a");
    @(posedge clk); #1;
    arst_n = 1'b1;
    idle();
    drive_res(1'b1, 32'h0);
    @(negedge clk);
    chk("t6a_first_res_wr_en", 32'(bht_wr_en), 32'd0);
    cycle_end();

    // 6b: reset during FLUSH
    drive_fetch(32'h24, 32'h900, 2'b00);
    cycle_end();
    drive_res(1'b1, 32'h28);
    expect_wr(5'd9, 2'b01);
    redir_q.push_back(32'h900);
    @(negedge clk);
    cycle_end();
    @(negedge clk);
    chk("t6b_in_flush", 32'(flush), 32'd1);
    @(posedge clk); #1;
    arst_n = 1'b0;
    @(negedge clk);
    check_reset_values("t6b");
    @(posedge clk); #1;
    arst_n = 1'b1;
    drive_res(1'b1, 32'h0);
    @(negedge clk);
    chk("t6b_first_res_wr_en", 32'(bht_wr_en), 32'd0);
    cycle_end();

    @(negedge clk);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("redir_q_drained", 32'(redir_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
